// File: rtl/scrolling_tile_map.sv
// Writable background tile map with a horizontally scrolling camera that follows Mario.
// Each VGA pixel request returns its tile code and in-tile offsets two cycles later.
module scrolling_tile_map #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int MAP_COLS        = 64,
  parameter int MAP_ROWS        = 12,
  parameter int TILE_BITS       = 2,
  parameter int SCROLL_MARGIN   = 240,
  parameter int MAX_SCROLL_STEP = 4
) (
  input  logic                           vga_clock,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic [31:0]                    mario_x,
  input  logic                           pixel_valid,
  input  logic [9:0]                     pixel_x,
  input  logic [9:0]                     pixel_y,
  input  logic                           wr_en,
  input  logic [$clog2(MAP_COLS)-1:0]    wr_col,
  input  logic [$clog2(MAP_ROWS)-1:0]    wr_row,
  input  logic [TILE_BITS-1:0]           wr_data,
  output logic                           tile_valid,
  output logic [TILE_BITS-1:0]           tile_type,
  output logic [$clog2(BLOCK_WIDTH)-1:0] tile_px,
  output logic [$clog2(BLOCK_WIDTH)-1:0] tile_py,
  output logic [31:0]                    scroll_x,
  output logic                           wr_ack,
  output logic                           wr_err
);

  localparam int COL_W    = $clog2(MAP_COLS);
  localparam int ROW_W    = $clog2(MAP_ROWS);
  localparam int PIX_W    = $clog2(BLOCK_WIDTH);
  localparam int MAP_BITS = MAP_ROWS * MAP_COLS * TILE_BITS;

  localparam logic [31:0] MAX_SCROLL = 32'(MAP_COLS * BLOCK_WIDTH - SCREEN_WIDTH);
  localparam logic [31:0] MARGIN     = 32'(SCROLL_MARGIN);
  localparam logic [31:0] STEP       = 32'(MAX_SCROLL_STEP);
  localparam logic [31:0] BLOCK_W32  = 32'(BLOCK_WIDTH);

  localparam logic [TILE_BITS-1:0] BDR = TILE_BITS'(0);
  localparam logic [TILE_BITS-1:0] SKY = TILE_BITS'(1);
  localparam logic [TILE_BITS-1:0] GND = TILE_BITS'(3);

  // Screen coordinates arrive on 10-bit ports, so the visible area must fit in them.
  if (BLOCK_WIDTH < 2 || SCREEN_WIDTH > 1024 || SCREEN_HEIGHT > 1024 ||
      MAP_COLS * BLOCK_WIDTH < SCREEN_WIDTH + BLOCK_WIDTH) begin : g_bad_geometry
    $error("scrolling_tile_map: unsupported screen/map geometry");
  end

  function automatic logic [TILE_BITS-1:0] reset_tile(input int r);
    if (r == 0 || r == MAP_ROWS - 1) return BDR;
    else if (r == MAP_ROWS - 2)      return GND;
    else                             return SKY;
  endfunction

  function automatic logic [MAP_BITS-1:0] init_map();
    logic [MAP_BITS-1:0] m;
    m = '0;
    for (int r = 0; r < MAP_ROWS; r++) begin
      for (int c = 0; c < MAP_COLS; c++) begin
        m[(r * MAP_COLS + c) * TILE_BITS +: TILE_BITS] = reset_tile(r);
      end
    end
    return m;
  endfunction

  localparam logic [MAP_BITS-1:0] MAP_INIT = init_map();

  // Camera: chase (mario_x - margin), clamped to the world, at most STEP pixels per frame.
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] next_scroll;

  always_comb begin
    target_raw = (mario_x > MARGIN) ? (mario_x - MARGIN) : 32'd0;
    target     = (target_raw > MAX_SCROLL) ? MAX_SCROLL : target_raw;
    if (target >= scroll_x) begin
      next_scroll = ((target - scroll_x) <= STEP) ? target : (scroll_x + STEP);
    end else begin
      next_scroll = ((scroll_x - target) <= STEP) ? target : (scroll_x - STEP);
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      scroll_x <= '0;
    end else if (frame_start) begin
      scroll_x <= next_scroll;
    end
  end

  logic [31:0] world_x;
  logic [31:0] col_full;
  logic [31:0] row_full;
  logic        in_map;

  always_comb begin
    world_x  = 32'(pixel_x) + scroll_x;
    col_full = world_x / BLOCK_W32;
    row_full = 32'(pixel_y) / BLOCK_W32;
    in_map   = (col_full < 32'(MAP_COLS)) && (row_full < 32'(MAP_ROWS));
  end

  logic             s1_valid;
  logic             s1_in_map;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic [PIX_W-1:0] s1_px;
  logic [PIX_W-1:0] s1_py;

  // Off-map requests get index 0 so the stage-2 read never leaves the array.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_in_map <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_px     <= '0;
      s1_py     <= '0;
    end else begin
      s1_valid  <= pixel_valid;
      s1_in_map <= in_map;
      s1_col    <= in_map ? COL_W'(col_full) : '0;
      s1_row    <= in_map ? ROW_W'(row_full) : '0;
      s1_px     <= PIX_W'(world_x % BLOCK_W32);
      s1_py     <= PIX_W'(32'(pixel_y) % BLOCK_W32);
    end
  end

  logic [MAP_BITS-1:0] map_q;
  logic [31:0]         rd_base;
  logic [31:0]         wr_base;
  logic                wr_in_range;

  always_comb begin
    rd_base     = (32'(s1_row) * 32'(MAP_COLS) + 32'(s1_col)) * 32'(TILE_BITS);
    wr_base     = (32'(wr_row) * 32'(MAP_COLS) + 32'(wr_col)) * 32'(TILE_BITS);
    wr_in_range = (32'(wr_col) < 32'(MAP_COLS)) && (32'(wr_row) < 32'(MAP_ROWS));
  end

  // A read and a write of the same tile on one edge see the old contents.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      tile_valid <= 1'b0;
      tile_type  <= '0;
      tile_px    <= '0;
      tile_py    <= '0;
    end else begin
      tile_valid <= s1_valid;
      tile_type  <= s1_in_map ? map_q[rd_base +: TILE_BITS] : BDR;
      tile_px    <= s1_px;
      tile_py    <= s1_py;
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      map_q  <= MAP_INIT;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_en && wr_in_range;
      wr_err <= wr_en && !wr_in_range;
      if (wr_en && wr_in_range) begin
        map_q[wr_base +: TILE_BITS] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_scrolling_tile_map.sv
// Randomised and directed bench for scrolling_tile_map against a tile-level model of the map,
// the camera rule and the two-cycle lookup.
module tb_scrolling_tile_map;

  localparam int BW     = 40;
  localparam int COLS   = 64;
  localparam int ROWS   = 12;
  localparam int MARGIN = 240;
  localparam int STEP   = 4;
  localparam int MAXS   = COLS * BW - 640;

  logic        vga_clock;
  logic        reset;
  logic        frame_start;
  logic [31:0] mario_x;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        wr_en;
  logic [5:0]  wr_col;
  logic [3:0]  wr_row;
  logic [1:0]  wr_data;
  logic        tile_valid;
  logic [1:0]  tile_type;
  logic [5:0]  tile_px;
  logic [5:0]  tile_py;
  logic [31:0] scroll_x;
  logic        wr_ack;
  logic        wr_err;

  int tests_run;
  int tests_failed;
  int cur_mx;

  int m_map [ROWS][COLS];
  int m_scroll;
  bit s1_valid;
  int s1_wx;
  int s1_y;
  bit e_valid;
  int e_type;
  int e_px;
  int e_py;
  bit e_ack;
  bit e_err;

  scrolling_tile_map #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .BLOCK_WIDTH(BW), .MAP_COLS(COLS),
    .MAP_ROWS(ROWS), .TILE_BITS(2), .SCROLL_MARGIN(MARGIN), .MAX_SCROLL_STEP(STEP)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .frame_start(frame_start), .mario_x(mario_x),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .tile_valid(tile_valid), .tile_type(tile_type), .tile_px(tile_px), .tile_py(tile_py),
    .scroll_x(scroll_x), .wr_ack(wr_ack), .wr_err(wr_err)
  );

  initial begin
    vga_clock = 1'b0;
    forever #5 vga_clock = ~vga_clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        m_map[r][c] = (r == 0 || r == ROWS - 1) ? 0 : (r == ROWS - 2) ? 3 : 1;
      end
    end
    m_scroll = 0;
    s1_valid = 0;
    s1_wx    = 0;
    s1_y     = 0;
    e_valid  = 0;
    e_type   = 0;
    e_px     = 0;
    e_py     = 0;
    e_ack    = 0;
    e_err    = 0;
  endtask

  // One clock edge of the model: finish last edge's request, capture the new one, write, move camera.
  task automatic model_advance(input bit pv, input int px, input int py, input bit fs, input int mx,
                               input bit we, input int wc, input int wr, input int wd);
    int col;
    int row;
    int target;
    e_valid = s1_valid;
    if (s1_valid) begin
      col    = s1_wx / BW;
      row    = s1_y / BW;
      e_type = (row < ROWS && col < COLS) ? m_map[row][col] : 0;
      e_px   = s1_wx % BW;
      e_py   = s1_y % BW;
    end
    s1_valid = pv;
    s1_wx    = px + m_scroll;
    s1_y     = py;
    e_ack = we && (wr < ROWS) && (wc < COLS);
    e_err = we && !((wr < ROWS) && (wc < COLS));
    if (e_ack) m_map[wr][wc] = wd;
    if (fs) begin
      target = (mx > MARGIN) ? mx - MARGIN : 0;
      if (target > MAXS) target = MAXS;
      if (target > m_scroll + STEP)      m_scroll = m_scroll + STEP;
      else if (target < m_scroll - STEP) m_scroll = m_scroll - STEP;
      else                               m_scroll = target;
    end
  endtask

  task automatic checkOutput();
    chk("tile_valid", tile_valid, e_valid);
    if (e_valid) begin
      chk("tile_type", tile_type, e_type);
      chk("tile_px", tile_px, e_px);
      chk("tile_py", tile_py, e_py);
    end
    chk("scroll_x", scroll_x, m_scroll);
    chk("wr_ack", wr_ack, e_ack);
    chk("wr_err", wr_err, e_err);
  endtask

  task automatic applyStimulus(input bit pv, input int px, input int py, input bit fs, input int mx,
                               input bit we, input int wc, input int wr, input int wd);
    @(negedge vga_clock);
    checkOutput();
    pixel_valid = pv;
    pixel_x     = 10'(px);
    pixel_y     = 10'(py);
    frame_start = fs;
    mario_x     = 32'(mx);
    cur_mx      = mx;
    wr_en       = we;
    wr_col      = 6'(wc);
    wr_row      = 4'(wr);
    wr_data     = 2'(wd);
    if (reset) model_advance(pv, px, py, fs, mx, we, wc, wr, wd);
    else       model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, cur_mx, 0, 0, 0, 0);
  endtask

  task automatic request(input int px, input int py);
    applyStimulus(1, px, py, 0, cur_mx, 0, 0, 0, 0);
  endtask

  task automatic frame(input int mx);
    applyStimulus(0, 0, 0, 1, mx, 0, 0, 0, 0);
  endtask

  task automatic write_tile(input int c, input int r, input int d);
    applyStimulus(0, 0, 0, 0, cur_mx, 1, c, r, d);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cur_mx       = 0;
    reset        = 1'b1;
    frame_start  = 1'b0;
    mario_x      = '0;
    pixel_valid  = 1'b0;
    pixel_x      = '0;
    pixel_y      = '0;
    wr_en        = 1'b0;
    wr_col       = '0;
    wr_row       = '0;
    wr_data      = '0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("reset_tile_valid", tile_valid, 0);
    chk("reset_tile_type", tile_type, 0);
    chk("reset_tile_px", tile_px, 0);
    chk("reset_tile_py", tile_py, 0);
    chk("reset_scroll_x", scroll_x, 0);
    chk("reset_wr_ack", wr_ack, 0);
    chk("reset_wr_err", wr_err, 0);
    idle(2);
    reset = 1'b1;

    request(0, 0);
    idle(2);
    chk("origin_valid", tile_valid, 1);
    chk("origin_type", tile_type, 0);
    chk("origin_px", tile_px, 0);
    chk("origin_py", tile_py, 0);

    repeat (10) begin frame(100); idle(1); end
    chk("scroll_held_at_0", scroll_x, 0);
    request(45, 405);
    idle(2);
    chk("ground_type", tile_type, 3);
    chk("ground_px", tile_px, 5);
    chk("ground_py", tile_py, 5);

    repeat (190) begin frame(1000); idle(1); end
    chk("scroll_760", scroll_x, 760);
    chk("model_scroll_760", m_scroll, 760);

    write_tile(20, 4, 2);
    idle(1);
    chk("write_ack", wr_ack, 1);
    chk("write_no_err", wr_err, 0);
    request(40, 160);
    idle(2);
    chk("written_block_type", tile_type, 2);
    chk("written_block_px", tile_px, 0);
    chk("model_block", m_map[4][20], 2);

    write_tile(5, 12, 2);
    idle(1);
    chk("bad_row_err", wr_err, 1);
    chk("bad_row_no_ack", wr_ack, 0);
    idle(1);
    chk("bad_row_err_pulse", wr_err, 0);

    request(120, 200);
    applyStimulus(1, 120, 200, 0, cur_mx, 1, 22, 5, 3);
    idle(1);
    chk("collision_old", tile_type, 1);
    idle(1);
    chk("collision_new", tile_type, 3);

    applyStimulus(1, 3, 0, 1, 5000, 0, 0, 0, 0);
    idle(2);
    chk("inflight_old_scroll_px", tile_px, 3);
    chk("scroll_764", scroll_x, 764);

    repeat (300) begin frame(5000); idle(1); end
    chk("scroll_clamp_1920", scroll_x, 1920);
    request(700, 405);
    idle(2);
    chk("off_map_col_type", tile_type, 0);
    chk("off_map_col_px", tile_px, 20);

    for (int i = 0; i < 3000; i++) begin
      int mx;
      mx = (i % 64 == 0) ? int'($urandom_range(0, 3000)) : cur_mx;
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0), mx,
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    write_tile(20, 4, 2);
    request(10, 10);
    request(20, 20);
    idle(1);
    #2 reset = 1'b0;
    #1;
    chk("midreset_tile_valid", tile_valid, 0);
    chk("midreset_tile_type", tile_type, 0);
    chk("midreset_tile_px", tile_px, 0);
    chk("midreset_tile_py", tile_py, 0);
    chk("midreset_scroll_x", scroll_x, 0);
    chk("midreset_wr_ack", wr_ack, 0);
    chk("midreset_wr_err", wr_err, 0);
    model_reset();
    idle(2);
    reset = 1'b1;
    request(800, 160);
    idle(2);
    chk("map_restored_type", tile_type, 1);
    chk("map_restored_px", tile_px, 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
